// File: rtl/ps2_kbd_port_if.sv
// ps2_kbd_port_if: CPU dmem-side bus for the PS/2 keyboard port.
// master = CPU side, slave = keyboard port.
interface ps2_kbd_port_if;
   logic        kbd_sel;
   logic        kbd_read;
   logic        kbd_write;
   logic        kbd_addr;
   logic        cpu_stall;
   logic [31:0] kbd_data_out;
   logic        kbd_irq;

   modport master (
      output kbd_sel, kbd_read, kbd_write, kbd_addr, cpu_stall,
      input  kbd_data_out, kbd_irq
   );

   modport slave (
      input  kbd_sel, kbd_read, kbd_write, kbd_addr, cpu_stall,
      output kbd_data_out, kbd_irq
   );
endinterface

// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port: memory-mapped PS/2 keyboard receiver with scan-code FIFO.
// Define KBD_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_kbd_port #(
   parameter int FIFO_DEPTH  = 16,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ps2_clk,
   input  logic          ps2_data,
   ps2_kbd_port_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

`ifdef KBD_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_PARITY,
      S_STOP
   } state_e;

   logic          ck_s1_q, ck_s1_d, ck_s2_q, ck_s2_d;
   logic          dt_s1_q, dt_s1_d, dt_s2_q, dt_s2_d;
   logic          filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          fall_q, fall_d;

   state_e        state_q, state_d;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    bit_q, bit_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          irq_q, irq_d;

   logic          push_req, ferr_set, perr_set;
   logic          not_empty, full, pop, push, ovf_set, clr;
   logic          rd_en;
   logic [7:0]    cnt8;
   logic [31:0]   rdata;

   // Synchronizers and ps2_clk glitch filter
   always_comb begin
      ck_s1_d = ps2_clk;
      ck_s2_d = ck_s1_q;
      dt_s1_d = ps2_data;
      dt_s2_d = dt_s1_q;
      filt_d  = filt_q;
      fcnt_d  = '0;
      if (ck_s2_q != filt_q) begin
         if (fcnt_q == FW'(FILTER_LEN - 1))
            filt_d = ck_s2_q;
         else
            fcnt_d = fcnt_q + 1'b1;
      end
      fall_d = filt_q & ~filt_d;
   end

   always_comb begin
      state_d  = state_q;
      sh_d     = sh_q;
      bit_d    = bit_q;
      par_d    = par_q;
      tmo_d    = tmo_q;
      push_req = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
      if (state_q != S_IDLE)
         tmo_d = fall_q ? '0 : tmo_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (fall_q && !dt_s2_q) begin
               sh_d    = '0;
               bit_d   = '0;
               tmo_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (fall_q) begin
               sh_d  = {dt_s2_q, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7)
                  state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            if (fall_q) begin
               par_d   = dt_s2_q;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (fall_q) begin
               state_d = S_IDLE;
               if (!dt_s2_q)
                  ferr_set = 1'b1;
               else if (PAR_CHK && !(^{sh_q, par_q}))
                  perr_set = 1'b1;
               else
                  push_req = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A stalled frame is abandoned; its partial byte is dropped
      if (state_q != S_IDLE && !fall_q &&
          tmo_q == TW'(TIMEOUT_CYC - 1)) begin
         state_d  = S_IDLE;
         ferr_set = 1'b1;
      end
   end

   always_comb begin
      not_empty = cnt_q != '0;
      full      = cnt_q == CW'(FIFO_DEPTH);
      pop       = bus.kbd_sel & bus.kbd_read & ~bus.kbd_addr &
                  ~bus.cpu_stall & not_empty;
      // A same-edge pop frees the slot for a push into a full FIFO
      push      = push_req & (~full | pop);
      ovf_set   = push_req & full & ~pop;
      clr       = bus.kbd_sel & bus.kbd_write & bus.kbd_addr &
                  ~bus.cpu_stall;
      mem_d     = mem_q;
      if (push)
         mem_d[wr_q] = sh_q;
      wr_d   = wr_q + PW'(push);
      rd_d   = rd_q + PW'(pop);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      ovf_d  = (ovf_q & ~clr) | ovf_set;
      ferr_d = (ferr_q & ~clr) | ferr_set;
      perr_d = (perr_q & ~clr) | perr_set;
      irq_d  = not_empty;
   end

   always_comb begin
      rd_en = bus.kbd_sel & bus.kbd_read;
      cnt8  = 8'(cnt_q);
      rdata = '0;
      unique case (1'b1)
         rd_en & ~bus.kbd_addr:
            rdata = not_empty ? {23'b0, 1'b1, mem_q[rd_q]} : '0;
         rd_en & bus.kbd_addr:
            rdata = {16'b0, cnt8, 4'b0,
                     perr_q, ferr_q, ovf_q, not_empty};
         default: rdata = '0;
      endcase
   end

   assign bus.kbd_data_out = rdata;
   assign bus.kbd_irq      = irq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ck_s1_q <= 1'b1;
         ck_s2_q <= 1'b1;
         dt_s1_q <= 1'b1;
         dt_s2_q <= 1'b1;
         filt_q  <= 1'b1;
         fcnt_q  <= '0;
         fall_q  <= 1'b0;
         state_q <= S_IDLE;
         sh_q    <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         tmo_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         ck_s1_q <= ck_s1_d;
         ck_s2_q <= ck_s2_d;
         dt_s1_q <= dt_s1_d;
         dt_s2_q <= dt_s2_d;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
         fall_q  <= fall_d;
         state_q <= state_d;
         sh_q    <= sh_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         tmo_q   <= tmo_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         irq_q   <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_ps2_kbd_port.sv
// tb_ps2_kbd_port: vector table plus scoreboard bench for ps2_kbd_port.
// Honours KBD_PARITY_CHECK_EN for its parity expectations.
module tb_ps2_kbd_port;
   logic clk = 1'b0;
   logic rst;
   logic ps2_clk;
   logic ps2_data;

   ps2_kbd_port_if bus();

   ps2_kbd_port dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .bus      (bus)
   );

   always #5 clk = ~clk;

`ifdef KBD_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   typedef struct {
      logic [7:0]  code;
      bit          bad_par;
      bit          bad_stop;
      logic [31:0] exp_st;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  sb_q [$];
   int          m_cnt   = 0;
   logic [31:0] pop_data;
   logic [31:0] d;
   logic [31:0] exp;
   vec_t        vecs [6];

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
      end
   endtask

   task automatic send_bit(input bit b, input bit pop_now);
      @(negedge clk);
      ps2_data = b;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_now) begin
         // Align the pop with the edge that samples this falling edge
         repeat (10) @(negedge clk);
         bus.kbd_sel  = 1'b1;
         bus.kbd_read = 1'b1;
         bus.kbd_addr = 1'b0;
         #1 pop_data = bus.kbd_data_out;
         @(negedge clk);
         bus.kbd_sel  = 1'b0;
         bus.kbd_read = 1'b0;
         repeat (9) @(negedge clk);
      end else begin
         repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par,
                             input bit bad_stop, input bit pop_stop);
      bit par;
      logic [31:0] e;
      par = ~^b;
      if (bad_par) par = ~par;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
      send_bit(par, 1'b0);
      send_bit(~bad_stop, pop_stop);
      if (pop_stop) begin
         if (m_cnt > 0) begin
            e = {23'b0, 1'b1, sb_q.pop_front()};
            m_cnt--;
            check("stop_edge_pop", pop_data, e);
         end else begin
            check("stop_edge_pop_empty", pop_data, 32'h0);
         end
      end
      if (!bad_stop && !(PCHK && bad_par) && m_cnt < 16) begin
         sb_q.push_back(b);
         m_cnt++;
      end
   endtask

   task automatic cpu_read(input bit addr, output logic [31:0] v);
      @(negedge clk);
      bus.kbd_sel  = 1'b1;
      bus.kbd_read = 1'b1;
      bus.kbd_addr = addr;
      #1 v = bus.kbd_data_out;
      @(negedge clk);
      bus.kbd_sel  = 1'b0;
      bus.kbd_read = 1'b0;
   endtask

   task automatic pop_check(input string name);
      logic [31:0] v;
      cpu_read(1'b0, v);
      if (sb_q.size() == 0) begin
         check({name, "_sb_empty"}, v, 32'h0);
      end else begin
         check(name, v, {23'b0, 1'b1, sb_q.pop_front()});
         m_cnt--;
      end
   endtask

   task automatic clear_flags();
      @(negedge clk);
      bus.kbd_sel   = 1'b1;
      bus.kbd_write = 1'b1;
      bus.kbd_addr  = 1'b1;
      @(negedge clk);
      bus.kbd_sel   = 1'b0;
      bus.kbd_write = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h1C, 1'b0, 1'b0, 32'h0000_0101};
      vecs[1] = '{8'h5A, 1'b1, 1'b0,
                  PCHK ? 32'h0000_0008 : 32'h0000_0101};
      vecs[2] = '{8'hA5, 1'b0, 1'b1, 32'h0000_0004};
      vecs[3] = '{8'hF0, 1'b0, 1'b0, 32'h0000_0101};
      vecs[4] = '{8'h00, 1'b0, 1'b0, 32'h0000_0101};
      vecs[5] = '{8'hFF, 1'b0, 1'b0, 32'h0000_0101};

      rst           = 1'b1;
      ps2_clk       = 1'b1;
      ps2_data      = 1'b1;
      bus.kbd_sel   = 1'b0;
      bus.kbd_read  = 1'b0;
      bus.kbd_write = 1'b0;
      bus.kbd_addr  = 1'b0;
      bus.cpu_stall = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;

      cpu_read(1'b0, d);
      check("reset_data", d, 32'h0);
      cpu_read(1'b1, d);
      check("reset_status", d, 32'h0);
      check("reset_irq", 32'(bus.kbd_irq), 32'h0);

      for (int i = 0; i < 6; i++) begin
         clear_flags();
         send_frame(vecs[i].code, vecs[i].bad_par,
                    vecs[i].bad_stop, 1'b0);
         repeat (2) @(negedge clk);
         cpu_read(1'b1, d);
         check($sformatf("vec%0d_status", i), d, vecs[i].exp_st);
         check($sformatf("vec%0d_irq", i), 32'(bus.kbd_irq),
               32'(vecs[i].exp_st[0]));
         while (m_cnt > 0) pop_check($sformatf("vec%0d_pop", i));
         cpu_read(1'b0, d);
         check($sformatf("vec%0d_empty", i), d, 32'h0);
      end

      // Overflow: 17 frames into a 16-entry FIFO
      clear_flags();
      for (int k = 1; k <= 17; k++)
         send_frame(8'(k), 1'b0, 1'b0, 1'b0);
      cpu_read(1'b1, d);
      check("ovf_status", d, 32'h0000_1003);
      check("ovf_irq", 32'(bus.kbd_irq), 32'h1);
      for (int k = 0; k < 16; k++) pop_check("ovf_pop");
      cpu_read(1'b1, d);
      check("ovf_sticky", d, 32'h0000_0002);
      clear_flags();
      cpu_read(1'b1, d);
      check("ovf_cleared", d, 32'h0);

      // Timeout after start + 4 bits
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      repeat (20010) @(negedge clk);
      cpu_read(1'b1, d);
      check("tmo_status", d, 32'h0000_0004);
      clear_flags();
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      pop_check("tmo_next_frame");
      cpu_read(1'b1, d);
      check("tmo_final_status", d, 32'h0);

      // Reset mid-frame; trailing all-ones bits must be ignored
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
      cpu_read(1'b1, d);
      check("rst_mid_status", d, 32'h0);
      check("rst_mid_irq", 32'(bus.kbd_irq), 32'h0);

      // Stalled read held 5 cycles, then released
      send_frame(8'h33, 1'b0, 1'b0, 1'b0);
      send_frame(8'h44, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.kbd_sel   = 1'b1;
      bus.kbd_read  = 1'b1;
      bus.kbd_addr  = 1'b0;
      bus.cpu_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 check("stall_hold", bus.kbd_data_out, 32'h0000_0133);
         @(negedge clk);
      end
      bus.cpu_stall = 1'b0;
      #1 d = bus.kbd_data_out;
      exp = {23'b0, 1'b1, sb_q.pop_front()};
      m_cnt--;
      check("stall_release", d, exp);
      @(negedge clk);
      bus.kbd_sel  = 1'b0;
      bus.kbd_read = 1'b0;
      cpu_read(1'b1, d);
      check("stall_one_pop", d, 32'h0000_0101);
      pop_check("stall_next");

      // Full FIFO: push and pop on the same edge
      for (int k = 0; k < 16; k++)
         send_frame(8'h20 + 8'(k), 1'b0, 1'b0, 1'b0);
      cpu_read(1'b1, d);
      check("full_status", d, 32'h0000_1001);
      send_frame(8'h77, 1'b0, 1'b0, 1'b1);
      cpu_read(1'b1, d);
      check("full_pushpop_status", d, 32'h0000_1001);
      for (int k = 0; k < 16; k++) pop_check("full_drain");
      cpu_read(1'b1, d);
      check("final_status", d, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_kbd_port.md
# ps2_kbd_port

Memory-mapped PS/2 keyboard receiver for the 0xe000_0000 I/O region of the CPU memory interface. It deserializes PS/2 device-to-host frames into scan codes and buffers them in a FIFO. The CPU reads it through the `dmem` read path: head scan code at word offset 0, status at word offset 1. It is the producer of `dmem_data_out` for the keyboard region and runs in the same clock domain as the pipeline.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: scan-code entries; power of two, at least 2.
- `FILTER_LEN`, 8: consecutive equal samples needed to accept a new `ps2_clk` level.
- `TIMEOUT_CYC`, 20000: maximum idle `clk` cycles between falling edges inside a frame.

Ports:
- `clk`  in  1: pipeline clock; all state updates on its rising edge. One clock domain only.
- `rst`  in  1: synchronous reset, active-high.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous.
- `ps2_data`  in  1: raw PS/2 data, asynchronous.
- `kbd_sel`  in  1: the `dmem` address falls in the keyboard region.
- `kbd_read`  in  1: `dmem` read request.
- `kbd_write`  in  1: `dmem` write request.
- `kbd_addr`  in  1: word offset inside the region; 0 = data, 1 = status.
- `cpu_stall`  in  1: pipeline stalled this cycle. While it is 1, no pop or flag clear takes effect.
- `kbd_data_out`  out  32: read data. Combinational from the current state.
- `kbd_irq`  out  1: registered; equals FIFO not-empty.

## Operation
- Input conditioning:
  - Two-flop synchronizers on both PS/2 lines.
  - `ps2_clk` glitch filter: the filtered level changes only after `FILTER_LEN` identical synchronized samples.
  - A falling edge of the filtered clock produces a one-cycle `fall` pulse. Data is sampled from the synchronized `ps2_data` at that pulse.
- Receive FSM: IDLE -> SHIFT -> PARITY -> STOP -> IDLE.
  - IDLE: on `fall` with data=0 (start bit), clear the shift register and bit counter and go to SHIFT. On `fall` with data=1, stay in IDLE.
  - SHIFT: on each `fall`, shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on `fall`, the frame is complete. It is valid if stop=1 and (see Configuration) odd parity holds.
    - Valid frame: push the byte.
    - Stop bit = 0: discard the byte and set `frame_err`.
  - Timeout: in any state other than IDLE, the counter reloads on every `fall`. If `TIMEOUT_CYC` cycles pass without a `fall`, return to IDLE, discard the partial byte and set `frame_err`.
- FIFO:
  - Circular buffer with read/write pointers of width log2(`FIFO_DEPTH`), which wrap naturally.
  - Count of width log2(`FIFO_DEPTH`)+1, so full = count==`FIFO_DEPTH`.
  - Push when full: the byte is dropped and sticky `overflow` is set.
- CPU read (combinational, valid every cycle `kbd_sel & kbd_read`):
  - Offset 0 returns {23'b0, not_empty, head[7:0]}. When the FIFO is empty it returns 0.
  - Offset 1 returns {16'b0, count[7:0], 4'b0, parity_err, frame_err, overflow, not_empty}.
  - Any read with `kbd_sel` = 0 returns 0.
- Pop: occurs on the edge where `kbd_sel & kbd_read & kbd_addr==0 & !cpu_stall & not_empty`. Exactly one pop per non-stalled read cycle.
- Flag clear: `kbd_sel & kbd_write & kbd_addr==1 & !cpu_stall` clears `overflow`, `frame_err` and `parity_err`. Writes to offset 0 are ignored.

## Timing
- Reset: FSM=IDLE, pointers=0, count=0, all flags=0, filtered clock=1, `kbd_irq`=0. `kbd_data_out` therefore evaluates to 0.
- Filter latency: the `fall` pulse occurs 2+`FILTER_LEN` cycles after the raw `ps2_clk` falling edge.
- Completion to visibility: the byte is in the FIFO on the edge that samples the stop bit's `fall`. It is visible on `kbd_data_out` in the next cycle; `kbd_irq` rises one cycle later.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, the pop frees the slot, so the push succeeds and no overflow is set.
  - When empty, no pop occurs and count becomes 1.
- Simultaneous flag clear and a new error event: the set wins.
- `rst` in the middle of a frame aborts it. Later bits of that frame are ignored until a data=0 `fall` is seen in IDLE.

## Configuration
- `KBD_PARITY_CHECK_EN`, defined:
  - A frame is valid only if the 9 bits (data + parity) contain an odd number of ones.
  - On a parity failure the byte is discarded and `parity_err` is set.
- Undefined: the parity bit is captured but ignored, every frame with stop=1 is pushed, and `parity_err` is constant 0.

## Test plan
- Send frame 0x1C with correct parity (FILTER_LEN=8) -> offset-0 read returns 0x0000011C. After the non-stalled read, count=0 and a second read returns 0x00000000.
- Send 17 frames 0x01..0x11 with `FIFO_DEPTH`=16 and no reads -> status = 0x00001003 (count 16, overflow, not_empty). Sixteen pops return 0x101..0x110; 0x11 is lost.
- Frame 0x5A with wrong parity, macro defined -> FIFO stays empty and status = 0x00000008. With the macro undefined -> 0x15A is buffered and status = 0x00000101.
- Send start + 4 bits, then hold `ps2_clk` high for `TIMEOUT_CYC`+10 cycles -> FSM in IDLE and status = 0x00000004. A following full frame 0xF0 is received correctly.
- Offset-0 read held with `cpu_stall`=1 for 5 cycles, then released -> exactly one pop occurs, on the release cycle.
- FIFO full, stop bit arrives on the same edge as a non-stalled pop -> count stays 16, overflow stays 0, and the new byte is at the tail.
